bcd_scan_counter: RTL and testbench
===================================

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles each digit is displayed; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: prescaler width; SHALL hold SCAN_DIV-1.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; asynchronous and active-high.
REQ-005 EN  input  1  count strobe; one count step per cycle in which it is high.
REQ-006 UP  input  1  direction; 1 = increment, 0 = decrement; sampled with EN.
REQ-007 LOAD  input  1  synchronous load of LOAD_VAL into the counter.
REQ-008 LOAD_VAL  input  16  four BCD digits, [15:12] = thousands, [3:0] = units.
REQ-009 COUNT  output  16  current four-digit BCD count, registered.
REQ-010 CARRY  output  1  one-cycle pulse on wrap (9999->0000 up, 0000->9999 down).
REQ-011 BCD  output  4  digit currently scanned; drives the downstream 7-segment decoder input.
REQ-012 AN  output  4  digit enables, active-low one-hot; AN[0] = units.

Function
REQ-013 Counter range 0000..9999 BCD; no digit SHALL ever hold a value above 9.
REQ-014 LOAD=1: COUNT <= LOAD_VAL next edge; any nibble >9 is loaded as 0; LOAD has priority over EN; CARRY=0 that cycle.
REQ-015 EN=1, LOAD=0, UP=1: units +1; a digit at 9 wraps to 0 and carries into the next digit.
REQ-016 EN=1, LOAD=0, UP=0: units -1; a digit at 0 wraps to 9 and borrows from the next digit.
REQ-017 CARRY SHALL be 1 for exactly the cycle after the wrapping step; otherwise 0.
REQ-018 EN=0 and LOAD=0: COUNT holds.
REQ-019 Prescaler counts 0..SCAN_DIV-1, then wraps to 0; it runs freely, independent of EN and LOAD.
REQ-020 Digit index IDX (0..3) advances 0->1->2->3->0 on the cycle the prescaler wraps.
REQ-021 BCD and AN SHALL be registered and update on the same edge as IDX, so they are always mutually consistent.
REQ-022 AN = 1110/1101/1011/0111 for IDX 0/1/2/3; exactly one bit SHALL be low at all times.
REQ-023 BCD SHALL show the digit value of COUNT one cycle earlier, so a count change appears on BCD within one cycle.
REQ-024 Scan period per full refresh = 4*SCAN_DIV cycles.

Reset
REQ-025 RST high SHALL immediately force: COUNT=0000, CARRY=0, prescaler=0, IDX=0, AN=1110, BCD=0000.
REQ-026 RST mid-count or mid-load SHALL discard the operation in progress.
REQ-027 On the first edge after RST falls, normal operation resumes from the reset state.

Structure
REQ-028 Shared package/include seg7_pkg: NUM_DIGITS=4, BCD_MAX=9, AN_OFF=4'b1111, one-hot active-low AN table.
REQ-029 One sub-module, bcd_digit: a single up/down BCD digit with ci/bi in and co/bo out.
REQ-030 Four bcd_digit instances SHALL be chained; scan logic and output muxing stay in the top level.
REQ-031 Target size 120-400 lines of RTL; no latches; no combinational path from inputs to BCD or AN.

Verification (SCAN_DIV=4 in simulation)
REQ-032 RST pulse mid-run -> COUNT=0000, AN=1110, BCD=0 during reset; AN advances to 1101 exactly 4 cycles after release.
REQ-033 LOAD, LOAD_VAL=16'h9998, UP=1, then EN for 2 cycles -> COUNT 9999 then 0000; CARRY high only in the 0000 cycle.
REQ-034 LOAD_VAL=16'h0000, UP=0, EN for 1 cycle -> COUNT=9999 and a single CARRY pulse.
REQ-035 LOAD_VAL=16'hA1F3 -> COUNT=0103.
REQ-036 LOAD and EN both high with LOAD_VAL=16'h1234 -> COUNT=1234 (no increment).
REQ-037 COUNT=4321 held for 16 cycles -> BCD sequence 1,2,3,4, each 4 cycles long, paired with AN 1110,1101,1011,0111.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the four-digit BCD scan display
package seg7_pkg;

  localparam int          NUM_DIGITS = 4;
  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam logic [3:0]  AN_OFF     = 4'b1111;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] idx_t;

  // Active-low one-hot digit enables, entry 0 drives the units digit
  localparam logic [3:0] AN_TABLE [NUM_DIGITS] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Pick one BCD digit out of the packed four-digit count
  function automatic bcd_t digit_of(input logic [15:0] value, input idx_t idx);
    case (idx)
      2'd0:    digit_of = value[3:0];
      2'd1:    digit_of = value[7:4];
      2'd2:    digit_of = value[11:8];
      default: digit_of = value[15:12];
    endcase
  endfunction

  // Clamp an out-of-range nibble to zero so no digit ever holds more than nine
  function automatic bcd_t sanitize(input logic [3:0] nib);
    sanitize = (nib > BCD_MAX) ? 4'd0 : nib;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one up/down BCD digit with carry and borrow chaining
module bcd_digit
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       ci,
  input  logic       bi,
  output logic [3:0] q,
  output logic       co,
  output logic       bo
);

  // Ripple outputs: this digit wraps on the same step that it is asked to move
  always_comb begin
    co = ci && (q == BCD_MAX);
    bo = bi && (q == 4'd0);
  end

  // Digit register: load beats step, step up on carry-in, step down on borrow-in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 4'd0;
    end else if (load) begin
      q <= sanitize(load_val);
    end else if (ci) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end else if (bi) begin
      q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - four-digit BCD up/down counter with multiplexed digit scan
module bcd_scan_counter
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        carry,
  output logic [3:0]  bcd,
  output logic [3:0]  an
);

  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(SCAN_DIV - 1);

  logic [3:0]       ci;
  logic [3:0]       bi;
  logic [3:0]       co;
  logic [3:0]       bo;
  logic [CNT_W-1:0] presc;
  idx_t             idx;
  idx_t             nidx;
  logic             presc_wrap;

  // The units digit is stepped by the strobe; higher digits take the ripple of the one below
  always_comb begin
    ci[0] = en && !load && up;
    bi[0] = en && !load && !up;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      ci[i] = co[i-1];
      bi[i] = bo[i-1];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val[4*g +: 4]),
      .ci       (ci[g]),
      .bi       (bi[g]),
      .q        (count[4*g +: 4]),
      .co       (co[g]),
      .bo       (bo[g])
    );
  end

  // Wrap flag: a ripple out of the top digit marks a full-range wrap in either direction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry <= 1'b0;
    end else begin
      carry <= co[NUM_DIGITS-1] || bo[NUM_DIGITS-1];
    end
  end

  // Next scan index, advanced only when the prescaler finishes a period
  always_comb begin
    presc_wrap = (presc == PRESC_MAX);
    nidx       = presc_wrap ? idx + 2'd1 : idx;
  end

  // Free-running prescaler and scan registers; bcd and an both follow the next index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= 2'd0;
      an    <= AN_TABLE[0];
      bcd   <= 4'd0;
    end else begin
      presc <= presc_wrap ? '0 : presc + CNT_W'(1);
      idx   <= nidx;
      an    <= AN_TABLE[nidx];
      bcd   <= digit_of(count, nidx);
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - directed self-checking bench for bcd_scan_counter
module tb_bcd_scan_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        carry;
  logic [3:0]  bcd;
  logic [3:0]  an;

  int n_checks;
  int n_errors;

  bcd_scan_counter #(.SCAN_DIV(4), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .carry    (carry),
    .bcd      (bcd),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    step();
    load     = 1'b0;
  endtask

  logic [3:0] exp_an [4];
  logic [3:0] exp_bcd [4];
  bit         synced;
  bit         seen_last;

  initial begin
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
    exp_bcd[0] = 4'd1;   exp_bcd[1] = 4'd2;   exp_bcd[2] = 4'd3;   exp_bcd[3] = 4'd4;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
    step();
    step();
    check("rst_count", count, 16'h0000);
    check("rst_carry", carry, 1'b0);
    check("rst_an",    an,    4'b1110);
    check("rst_bcd",   bcd,   4'd0);

    // First scan step after release lands four edges later
    rst = 1'b0;
    step(); step(); step();
    check("rel_an_3", an, 4'b1110);
    step();
    check("rel_an_4", an, 4'b1101);

    // Up-count wrap 9998 -> 9999 -> 0000 with a single carry cycle
    up = 1'b1;
    do_load(16'h9998);
    check("ld_9998", count, 16'h9998);
    check("ld_carry", carry, 1'b0);
    en = 1'b1;
    step();
    check("up_9999", count, 16'h9999);
    check("up_9999_carry", carry, 1'b0);
    step();
    check("up_0000", count, 16'h0000);
    check("up_wrap_carry", carry, 1'b1);
    en = 1'b0;
    step();
    check("up_hold", count, 16'h0000);
    check("up_carry_drop", carry, 1'b0);

    // Down-count wrap 0000 -> 9999
    do_load(16'h0000);
    up = 1'b0;
    en = 1'b1;
    step();
    en = 1'b0;
    check("dn_9999", count, 16'h9999);
    check("dn_wrap_carry", carry, 1'b1);
    step();
    check("dn_hold", count, 16'h9999);
    check("dn_carry_drop", carry, 1'b0);

    // Out-of-range nibbles load as zero
    do_load(16'hA1F3);
    check("ld_sanitize", count, 16'h0103);

    // Load wins over enable
    up = 1'b1;
    en = 1'b1;
    do_load(16'h1234);
    en = 1'b0;
    check("ld_over_en", count, 16'h1234);
    check("ld_over_en_carry", carry, 1'b0);
    step(); step();
    check("hold", count, 16'h1234);

    // Multi-digit ripple in both directions without a full wrap
    do_load(16'h0199);
    en = 1'b1; up = 1'b1;
    step();
    en = 1'b0;
    check("ripple_up", count, 16'h0200);
    check("ripple_up_carry", carry, 1'b0);
    do_load(16'h1000);
    en = 1'b1; up = 1'b0;
    step();
    en = 1'b0;
    check("ripple_dn", count, 16'h0999);
    check("ripple_dn_carry", carry, 1'b0);

    // Reset in the middle of a load must take effect at once and discard the load
    load = 1'b1; load_val = 16'h5555; en = 1'b1; up = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_count", count, 16'h0000);
    check("mid_rst_an",    an,    4'b1110);
    check("mid_rst_bcd",   bcd,   4'd0);
    check("mid_rst_carry", carry, 1'b0);
    load = 1'b0; en = 1'b0;
    step();
    rst = 1'b0;
    step(); step(); step();
    check("mid_rel_an_3", an, 4'b1110);
    step();
    check("mid_rel_an_4", an, 4'b1101);
    check("mid_rel_count", count, 16'h0000);

    // Scan a held 4321: align to the start of a units slot, then walk 16 cycles
    do_load(16'h4321);
    synced = 1'b0;
    seen_last = 1'b0;
    for (int i = 0; i < 40 && !synced; i++) begin
      if (an == 4'b0111) seen_last = 1'b1;
      else if (seen_last && an == 4'b1110) synced = 1'b1;
      if (!synced) step();
    end
    check("scan_sync", synced, 1'b1);
    if (synced) begin
      for (int k = 0; k < 16; k++) begin
        check($sformatf("scan_an_%0d", k),  an,  exp_an[k/4]);
        check($sformatf("scan_bcd_%0d", k), bcd, exp_bcd[k/4]);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
